uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among NUM_REQ byte producers.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_rr_picker.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbiter slice.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    localparam int unsigned OVERSAMPLE_DEF = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-producer and transmitter handshake bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GRANT_W = 2
) ();
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 baud_tick;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic [GRANT_W-1:0]   grant_id;
    logic                 arb_busy;
    logic                 err_timeout;

    modport slave (
        input  req_valid, req_data, baud_tick, tx_busy, tx_done,
        output req_ready, tx_start, tx_data, grant_id, arb_busy, err_timeout
    );

    modport master (
        output req_valid, req_data, baud_tick, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data, grant_id, arb_busy, err_timeout
    );
endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin pick: first set request after last_grant, with wrap.
module uart_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GRANT_W = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [GRANT_W-1:0] idx,
    output logic               any
);
    logic found;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        grant = '0;
        // Upper half (above last_grant) first, then wrap to the lowest set bit.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (GRANT_W'(i) > last_grant)) begin
                found = 1'b1;
                idx   = GRANT_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = GRANT_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant[i] = found && (idx == GRANT_W'(i));
        end
        any = found;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Optional SEND watchdog enabled by defining UART_TX_ARB_WATCHDOG_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned GRANT_W     = 2,
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int unsigned GAP_BITS    = 1,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_tx_arbiter_if.slave   bus
);
    localparam int unsigned GAP_TERM = GAP_BITS * OVERSAMPLE;
    localparam int unsigned GAP_W    = (clog2(GAP_TERM + 1) > 0) ? clog2(GAP_TERM + 1) : 1;
    localparam int unsigned GAP_LAST = (GAP_TERM > 0) ? GAP_TERM - 1 : 0;

    if (GRANT_W != clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("uart_tx_arbiter: inconsistent parameters");
    end

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] last_grant_q, last_grant_d;
    logic [GRANT_W-1:0] grant_id_q, grant_id_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               tx_start;
    logic               err_timeout;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [GRANT_W-1:0] pick_idx;
    logic               pick_any;
    logic [7:0]         sel_byte;

`ifdef UART_TX_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = (clog2(TIMEOUT_CYC) > 0) ? clog2(TIMEOUT_CYC) : 1;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_onehot),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        sel_byte = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == GRANT_W'(i)) sel_byte = bus.req_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_data_d    = tx_data_q;
        gap_cnt_d    = gap_cnt_q;
        tx_start     = 1'b0;
        err_timeout  = 1'b0;
`ifdef UART_TX_ARB_WATCHDOG_EN
        wd_cnt_d     = wd_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    tx_data_d    = sel_byte;
                    grant_id_d   = pick_idx;
                    last_grant_d = pick_idx;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = ST_SEND;
`ifdef UART_TX_ARB_WATCHDOG_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            ST_SEND: begin
                // tx_done takes priority over a watchdog expiry in the same cycle.
                if (bus.tx_done) begin
                    state_d = (GAP_TERM != 0) ? ST_GAP : ST_IDLE;
                end
`ifdef UART_TX_ARB_WATCHDOG_EN
                else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    err_timeout = 1'b1;
                    state_d     = ST_GAP;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (GAP_TERM == 0) begin
                    state_d = ST_IDLE;
                end else if (bus.baud_tick) begin
                    if (gap_cnt_q >= GAP_W'(GAP_LAST)) begin
                        gap_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            gap_cnt_q    <= '0;
`ifdef UART_TX_ARB_WATCHDOG_EN
            wd_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_data_q    <= tx_data_d;
            gap_cnt_q    <= gap_cnt_d;
`ifdef UART_TX_ARB_WATCHDOG_EN
            wd_cnt_q     <= wd_cnt_d;
`endif
        end
    end

    // req_ready is combinational, so it is also masked while reset is asserted.
    assign bus.req_ready   = (reset_n && state_q == ST_IDLE) ? pick_onehot : '0;
    assign bus.tx_start    = tx_start;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.arb_busy    = (state_q != ST_IDLE);
    assign bus.err_timeout = err_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: randomized producers against a round-robin reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int GAP_BITS  = 2;
    localparam int OVS       = 16;
    localparam int GAP_TICKS = GAP_BITS * OVS;
    localparam int TIMEOUT   = 100;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   last_grant;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .GRANT_W(2)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .GRANT_W     (2),
        .OVERSAMPLE  (OVS),
        .GAP_BITS    (GAP_BITS),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete in time");
        $fatal(1, "time limit reached");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first valid requester strictly after the last grant, wrapping.
    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (last + k) % NUM_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Handshake in IDLE, optional transmitter stall, launch; ends in the first SEND cycle.
    task automatic grant_phase(input int busy_cyc, input bit refill);
        int w;
        logic [7:0] eb;
        #1;
        w = model_pick(bus.req_valid, last_grant);
        chk("req_ready", 32'(bus.req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        chk("idle_busy", 32'(bus.arb_busy), 32'd0);
        eb = bus.req_data[8*w +: 8];
        step();
        last_grant = w;
        chk("grant_id", 32'(bus.grant_id), 32'(w));
        chk("tx_data", 32'(bus.tx_data), 32'(eb));
        chk("issue_busy", 32'(bus.arb_busy), 32'd1);
        chk("issue_ready", 32'(bus.req_ready), 32'd0);
        if (refill) bus.req_data[8*w +: 8] = 8'($urandom);
        else        bus.req_valid[w] = 1'b0;
        bus.tx_busy = (busy_cyc > 0);
        for (int i = 0; i < busy_cyc; i++) begin
            #1;
            chk("stall_no_start", 32'(bus.tx_start), 32'd0);
            step();
        end
        bus.tx_busy = 1'b0;
        #1;
        chk("tx_start", 32'(bus.tx_start), 32'd1);
        step();
        chk("start_pulse_end", 32'(bus.tx_start), 32'd0);
        chk("send_ready", 32'(bus.req_ready), 32'd0);
    endtask

    // SEND with stray baud ticks, then tx_done together with a tick that must not count.
    task automatic send_phase(input int n);
        for (int i = 0; i < n; i++) begin
            bus.baud_tick = 1'($urandom_range(0, 1));
            step();
            bus.baud_tick = 1'b0;
        end
        chk("send_busy", 32'(bus.arb_busy), 32'd1);
        bus.tx_done   = 1'b1;
        bus.baud_tick = 1'b1;
        #1;
        chk("done_no_err", 32'(bus.err_timeout), 32'd0);
        step();
        bus.tx_done   = 1'b0;
        bus.baud_tick = 1'b0;
    endtask

    // Exactly GAP_TICKS baud ticks, randomly spaced, with ignored tx_done pulses.
    task automatic gap_phase();
        for (int t = 1; t <= GAP_TICKS; t++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.tx_done = 1'($urandom_range(0, 1));
                step();
                bus.tx_done = 1'b0;
            end
            bus.baud_tick = 1'b1;
            step();
            bus.baud_tick = 1'b0;
            chk("gap_busy", 32'(bus.arb_busy), (t < GAP_TICKS) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.baud_tick = 1'b0;
        bus.tx_busy   = 1'b0;
        bus.tx_done   = 1'b0;
        last_grant    = NUM_REQ - 1;
        repeat (2) step();

        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_start", 32'(bus.tx_start), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
        chk("rst_grant", 32'(bus.grant_id), 32'd0);
        chk("rst_busy", 32'(bus.arb_busy), 32'd0);
        chk("rst_err", 32'(bus.err_timeout), 32'd0);
        reset_n = 1'b1;
        step();

        // Single requester 2 with 8'hA5.
        bus.req_data          = $urandom;
        bus.req_data[23:16]   = 8'hA5;
        bus.req_valid         = 4'b0100;
        grant_phase(0, 0);
        chk("single_grant2", 32'(bus.grant_id), 32'd2);
        chk("single_a5", 32'(bus.tx_data), 32'hA5);
        send_phase(5);
        gap_phase();

        // Transmitter busy for 50 cycles while in ISSUE.
        bus.req_valid = 4'($urandom_range(1, 15));
        grant_phase(50, 0);
        send_phase(3);
        gap_phase();

        // Random producer patterns, including dropping unserved requests.
        for (int f = 0; f < 10; f++) begin
            bus.req_data  = $urandom;
            bus.req_valid = 4'($urandom_range(1, 15));
            grant_phase($urandom_range(0, 3), 0);
            send_phase($urandom_range(1, 20));
            gap_phase();
        end

        // Reset asserted mid-SEND with all requesters pending.
        bus.req_valid = 4'b1010;
        grant_phase(0, 0);
        bus.req_valid = '1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.arb_busy), 32'd0);
        chk("mid_rst_start", 32'(bus.tx_start), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_grant", 32'(bus.grant_id), 32'd0);
        chk("mid_rst_data", 32'(bus.tx_data), 32'd0);
        step();
        step();
        reset_n    = 1'b1;
        last_grant = NUM_REQ - 1;

        // All four requesting continuously: grants 0,1,2,3,0.
        for (int f = 0; f < 5; f++) begin
            grant_phase(0, 1);
            chk("rr_order", 32'(bus.grant_id), 32'(f % NUM_REQ));
            send_phase($urandom_range(1, 10));
            gap_phase();
        end

`ifdef UART_TX_ARB_WATCHDOG_EN
        // tx_done withheld: expiry in SEND cycle TIMEOUT, then GAP and the next requester.
        grant_phase(0, 1);
        for (int n = 1; n < TIMEOUT; n++) begin
            #1;
            chk("wd_quiet", 32'(bus.err_timeout), 32'd0);
            step();
        end
        #1;
        chk("wd_fire", 32'(bus.err_timeout), 32'd1);
        step();
        chk("wd_pulse_end", 32'(bus.err_timeout), 32'd0);
        chk("wd_gap_busy", 32'(bus.arb_busy), 32'd1);
        gap_phase();
        // tx_done in SEND cycle TIMEOUT-1: no error.
        grant_phase(0, 1);
        for (int n = 1; n < TIMEOUT - 1; n++) step();
        bus.tx_done = 1'b1;
        #1;
        chk("wd_late_done", 32'(bus.err_timeout), 32'd0);
        step();
        bus.tx_done = 1'b0;
        gap_phase();
`else
        // Without the watchdog SEND waits indefinitely.
        grant_phase(0, 1);
        repeat (150) step();
        chk("nowd_err", 32'(bus.err_timeout), 32'd0);
        chk("nowd_busy", 32'(bus.arb_busy), 32'd1);
        send_phase(1);
        gap_phase();
`endif
        grant_phase(0, 1);
        send_phase(2);
        gap_phase();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
